clk_divider: RTL and testbench

CLK_DIVIDER -- requirements
Module: clk_divider

---
 rtl/clk_divider.sv | 109 ++++++++++
 tb/tb_clk_divider.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/clk_divider.sv
// clk_divider: programmable integer clock divider driven by pclock.
//
// Ports:
//   pclock      in            sole clock, rising-edge
//   reset       in            synchronous, active-high
//   en          in            level request for the divided clock
//   div_ratio   in  RATIO_W   requested ratio N (0 and 1 act as 2)
//   dclock      out           registered divided clock, HI cycles high then N-HI low
//   running     out           high while RUN or STOP
//   period_tick out           one-cycle pulse on the first cycle of each dclock period
//   ratio_q     out RATIO_W   active (clamped) ratio
//
// HI = N - floor(N/2). A new ratio is only picked up at period boundaries.
// Dropping en lets the current period finish before returning to idle.
module clk_divider #(
  parameter int unsigned RATIO_W = 8
) (
  input  logic               pclock,
  input  logic               reset,
  input  logic               en,
  input  logic [RATIO_W-1:0] div_ratio,
  output logic               dclock,
  output logic               running,
  output logic               period_tick,
  output logic [RATIO_W-1:0] ratio_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [RATIO_W-1:0] cnt, cnt_d;
  logic [RATIO_W-1:0] n, n_d;
  logic [RATIO_W-1:0] hi_d;
  logic [RATIO_W-1:0] ratio_clamped;
  logic               dclock_d;
  logic               tick_d;
  logic               wrap;

  assign ratio_clamped = (div_ratio < RATIO_W'(2)) ? RATIO_W'(2) : div_ratio;
  assign wrap          = (cnt == n - RATIO_W'(1));

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    n_d      = n;
    tick_d   = 1'b0;
    hi_d     = '0;
    dclock_d = 1'b0;

    case (state)
      IDLE: begin
        cnt_d = '0;
        if (en) begin
          state_d = RUN;
          n_d     = ratio_clamped;
          tick_d  = 1'b1;
        end
      end
      RUN, STOP: begin
        if (wrap) begin
          cnt_d = '0;
          if (state == STOP && !en) begin
            state_d = IDLE;
          end else begin
            state_d = en ? RUN : STOP;
            n_d     = ratio_clamped;
            tick_d  = 1'b1;
          end
        end else begin
          cnt_d   = cnt + RATIO_W'(1);
          state_d = en ? RUN : STOP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // High phase is derived from the ratio that will be active after this
    // edge, so a ratio loaded on a wrap shapes the new period from its first cycle.
    hi_d     = n_d - {1'b0, n_d[RATIO_W-1:1]};
    dclock_d = (state_d != IDLE) && (cnt_d < hi_d);
  end

  always_ff @(posedge pclock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      n           <= RATIO_W'(2);
      dclock      <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      n           <= n_d;
      dclock      <= dclock_d;
      period_tick <= tick_d;
    end
  end

  assign running = (state != IDLE);
  assign ratio_q = n;

endmodule

// File: tb/tb_clk_divider.sv
// Directed-vector scoreboard bench for clk_divider. The stimulus process
// pushes the hand-computed outputs expected after each pclock edge; a monitor
// process pops and compares them shortly after that edge.
module tb_clk_divider;

  logic       pclock = 1'b0;
  logic       reset  = 1'b1;
  logic       en     = 1'b0;
  logic [7:0] div_ratio = 8'd0;
  logic       dclock, running, period_tick;
  logic [7:0] ratio_q;

  clk_divider #(.RATIO_W(8)) dut (
    .pclock      (pclock),
    .reset       (reset),
    .en          (en),
    .div_ratio   (div_ratio),
    .dclock      (dclock),
    .running     (running),
    .period_tick (period_tick),
    .ratio_q     (ratio_q)
  );

  always #5 pclock = ~pclock;

  typedef struct {
    int unsigned id;
    logic        d;
    logic        t;
    logic        r;
    logic [7:0]  q;
  } exp_s;

  exp_s        sb[$];
  int unsigned edge_cnt = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  always @(posedge pclock) edge_cnt <= edge_cnt + 1;

  // Monitor: outputs after edge k are compared against the entry tagged k.
  initial begin
    exp_s e;
    forever begin
      @(posedge pclock);
      #1;
      while (sb.size() > 0 && sb[0].id < edge_cnt) begin
        e = sb.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missed_edge id=%0d: now at edge %0d, required checking at %0d", e.id, edge_cnt, e.id);
      end
      if (sb.size() > 0 && sb[0].id == edge_cnt) begin
        e = sb.pop_front();
        n_checks++;
        if (dclock !== e.d) begin
          n_fail++;
          $display("FAIL dclock edge=%0d: got %b, required %b", e.id, dclock, e.d);
        end
        n_checks++;
        if (period_tick !== e.t) begin
          n_fail++;
          $display("FAIL period_tick edge=%0d: got %b, required %b", e.id, period_tick, e.t);
        end
        n_checks++;
        if (running !== e.r) begin
          n_fail++;
          $display("FAIL running edge=%0d: got %b, required %b", e.id, running, e.r);
        end
        n_checks++;
        if (ratio_q !== e.q) begin
          n_fail++;
          $display("FAIL ratio_q edge=%0d: got %0d, required %0d", e.id, ratio_q, e.q);
        end
      end
    end
  end

  // Called at a negedge: drive inputs for the next posedge and log its outcome.
  task automatic cyc(input logic rst, input logic e_n, input logic [7:0] ratio,
                     input logic ed, input logic et, input logic er, input logic [7:0] eq);
    exp_s x;
    reset     = rst;
    en        = e_n;
    div_ratio = ratio;
    x.id = edge_cnt + 1;
    x.d  = ed;
    x.t  = et;
    x.r  = er;
    x.q  = eq;
    sb.push_back(x);
    @(negedge pclock);
  endtask

  // Repeat a hand-written pattern; bit len-1 of dp/tp is the first cycle.
  task automatic pat(input logic e_n, input logic [7:0] ratio,
                     input logic [15:0] dp, input logic [15:0] tp,
                     input int len, input int reps, input logic er, input logic [7:0] eq);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < len; i++)
        cyc(1'b0, e_n, ratio, dp[len-1-i], tp[len-1-i], er, eq);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd2);
  endtask

  initial begin
    @(negedge pclock);

    // Reset dominates en; then N=4 gives 1,1,0,0 with tick on the first high.
    cyc(1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 8'd2);
    cyc(1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 8'd2);
    pat(1'b1, 8'd4, 16'b1100, 16'b1000, 4, 3, 1'b1, 8'd4);

    // N=3 -> 1,1,0
    do_reset();
    pat(1'b1, 8'd3, 16'b110, 16'b100, 3, 3, 1'b1, 8'd3);

    // Ratios 0 and 1 clamp to 2 -> 1,0
    do_reset();
    pat(1'b1, 8'd0, 16'b10, 16'b10, 2, 3, 1'b1, 8'd2);
    pat(1'b1, 8'd1, 16'b10, 16'b10, 2, 3, 1'b1, 8'd2);

    // N=4, ratio changed to 6 while cnt=1: period finishes at 4, then 1,1,1,0,0,0
    do_reset();
    pat(1'b1, 8'd4, 16'b11, 16'b10, 2, 1, 1'b1, 8'd4);
    pat(1'b1, 8'd6, 16'b00, 16'b00, 2, 1, 1'b1, 8'd4);
    pat(1'b1, 8'd6, 16'b111000, 16'b100000, 6, 2, 1'b1, 8'd6);

    // N=8, en dropped at cnt=2: 4 high + 4 low, then idle with no extra tick
    do_reset();
    pat(1'b1, 8'd8, 16'b111, 16'b100, 3, 1, 1'b1, 8'd8);
    pat(1'b0, 8'd8, 16'b10000, 16'b00000, 5, 1, 1'b1, 8'd8);
    pat(1'b0, 8'd8, 16'b0000, 16'b0000, 4, 1, 1'b0, 8'd8);

    // en dropped for one cycle mid-period: identical to uninterrupted N=4
    do_reset();
    cyc(1'b0, 1'b1, 8'd4, 1'b1, 1'b1, 1'b1, 8'd4);
    cyc(1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b1, 8'd4);
    cyc(1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b1, 8'd4);
    cyc(1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b1, 8'd4);
    pat(1'b1, 8'd4, 16'b1100, 16'b1000, 4, 1, 1'b1, 8'd4);
    // en low into STOP, reasserted exactly on the wrap edge: new period starts
    cyc(1'b0, 1'b1, 8'd4, 1'b1, 1'b1, 1'b1, 8'd4);
    cyc(1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b1, 8'd4);
    cyc(1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b1, 8'd4);
    cyc(1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b1, 8'd4);
    cyc(1'b0, 1'b1, 8'd4, 1'b1, 1'b1, 1'b1, 8'd4);
    pat(1'b1, 8'd4, 16'b100, 16'b000, 3, 1, 1'b1, 8'd4);

    // Reset at N=6, cnt=2: truncates, then RUN restarts on the next edge
    do_reset();
    pat(1'b1, 8'd6, 16'b111, 16'b100, 3, 1, 1'b1, 8'd6);
    cyc(1'b1, 1'b1, 8'd6, 1'b0, 1'b0, 1'b0, 8'd2);
    pat(1'b1, 8'd6, 16'b111000, 16'b100000, 6, 2, 1'b1, 8'd6);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge pclock);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
